spi_bridge_3w: RTL

SPI_BRIDGE_3W -- requirements
Module: spi_bridge_3w

---
 rtl/spi_bridge_pkg.sv | 25 ++
 rtl/spi_edge_sync.sv | 51 +++++
 rtl/spi_bridge_3w.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/spi_bridge_pkg.sv
// Shared types and helpers for the 3-wire SPI bridge.
// State encoding and sclk sample-edge selection.
package spi_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CMD  = 3'd1,
    ADDR = 3'd2,
    DATA = 3'd3,
    HOLD = 3'd4
  } state_t;

  // Sample on the rising sclk edge when CPOL and CPHA agree.
  function automatic logic sample_on_rise(
    input logic cpol,
    input logic cpha
  );
    return cpol == cpha;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// Synchronises sclk/cs/sdi into sysclk and flags
// the mode-dependent sample edge of sclk.
module spi_edge_sync
  import spi_bridge_pkg::*;
#(
  parameter int CPOL        = 0,
  parameter int CPHA        = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic sysclk,
  input  logic sysrst,
  input  logic sclk,
  input  logic cs,
  input  logic sdi,
  output logic cs_n_sync,
  output logic sdi_sync,
  output logic sample_pulse
);

  localparam logic RISE = sample_on_rise(1'(CPOL), 1'(CPHA));
  localparam logic IDLE_SCLK = 1'(CPOL);

  logic [SYNC_STAGES-1:0] sclk_q;
  logic [SYNC_STAGES-1:0] cs_q;
  logic [SYNC_STAGES-1:0] sdi_q;
  logic                   sclk_d;
  logic                   sclk_s;

  // Shift chains, reset to the bus idle levels.
  always_ff @(posedge sysclk or posedge sysrst) begin
    if (sysrst) begin
      sclk_q <= {SYNC_STAGES{IDLE_SCLK}};
      cs_q   <= '1;
      sdi_q  <= '0;
      sclk_d <= IDLE_SCLK;
    end else begin
      sclk_q <= {sclk_q[SYNC_STAGES-2:0], sclk};
      cs_q   <= {cs_q[SYNC_STAGES-2:0], cs};
      sdi_q  <= {sdi_q[SYNC_STAGES-2:0], sdi};
      sclk_d <= sclk_q[SYNC_STAGES-1];
    end
  end

  assign sclk_s    = sclk_q[SYNC_STAGES-1];
  assign cs_n_sync = cs_q[SYNC_STAGES-1];
  assign sdi_sync  = sdi_q[SYNC_STAGES-1];

  assign sample_pulse = RISE ? (sclk_s & ~sclk_d)
                             : (~sclk_s & sclk_d);

endmodule

// File: rtl/spi_bridge_3w.sv
// 4-wire to 3-wire SPI bridge: decodes R/W + address
// and turns sdio around for the read data phase.
// Build option: SPI_BRIDGE_BURST_EN keeps DATA running.
module spi_bridge_3w
  import spi_bridge_pkg::*;
#(
  parameter int WIDTH_ADDR    = 10,
  parameter int WIDTH_DATA    = 8,
  parameter int READ_POLARITY = 1,
  parameter int CPOL          = 0,
  parameter int CPHA          = 0,
  parameter int SYNC_STAGES   = 2
) (
  input  logic sysclk,
  input  logic sysrst,
  input  logic sclk,
  input  logic cs,
  input  logic sdi,
  output logic sdo,
  inout  wire  sdio,
  output logic o_cs,
  output logic o_sclk,
  output logic rd_active,
  output logic busy,
  output logic frame_err
);

  localparam int MAXW = max2(WIDTH_ADDR, WIDTH_DATA);
  localparam int CW   = $clog2(MAXW + 1);

  localparam logic [CW-1:0] ADDR_LAST = CW'(WIDTH_ADDR - 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(WIDTH_DATA - 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic          rd;
  logic          cs_d;
  logic          cs_n_sync;
  logic          sdi_sync;
  logic          sample;
  logic          cs_fall;
  logic          cs_rise;

  spi_edge_sync #(
    .CPOL        (CPOL),
    .CPHA        (CPHA),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .sysclk       (sysclk),
    .sysrst       (sysrst),
    .sclk         (sclk),
    .cs           (cs),
    .sdi          (sdi),
    .cs_n_sync    (cs_n_sync),
    .sdi_sync     (sdi_sync),
    .sample_pulse (sample)
  );

  assign cs_fall = cs_d & ~cs_n_sync;
  assign cs_rise = ~cs_d & cs_n_sync;

  // Previous synchronised cs for edge detection.
  always_ff @(posedge sysclk or posedge sysrst) begin
    if (sysrst) begin
      cs_d <= 1'b1;
    end else begin
      cs_d <= cs_n_sync;
    end
  end

  // Frame FSM: command bit, address, data words.
  always_ff @(posedge sysclk or posedge sysrst) begin
    if (sysrst) begin
      state     <= IDLE;
      cnt       <= '0;
      rd        <= 1'b0;
      rd_active <= 1'b0;
      busy      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      if (cs_rise) begin
        state     <= IDLE;
        cnt       <= '0;
        rd_active <= 1'b0;
        busy      <= 1'b0;
        frame_err <= (state == CMD) || (state == ADDR) ||
                     ((state == DATA) && (cnt != '0));
      end else begin
        case (state)
          IDLE: begin
            if (cs_fall) begin
              state <= CMD;
              cnt   <= '0;
              busy  <= 1'b1;
            end
          end
          CMD: begin
            if (sample) begin
              rd    <= (sdi_sync == 1'(READ_POLARITY));
              state <= ADDR;
              cnt   <= '0;
            end
          end
          ADDR: begin
            if (sample) begin
              if (cnt == ADDR_LAST) begin
                state     <= DATA;
                cnt       <= '0;
                rd_active <= rd;
              end else begin
                cnt <= cnt + CW'(1);
              end
            end
          end
          DATA: begin
            if (sample) begin
              if (cnt == DATA_LAST) begin
                cnt <= '0;
`ifdef SPI_BRIDGE_BURST_EN
                state <= DATA;
`else
                state     <= HOLD;
                rd_active <= 1'b0;
`endif
              end else begin
                cnt <= cnt + CW'(1);
              end
            end
          end
          HOLD: begin
            rd_active <= 1'b0;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

  assign sdio   = rd_active ? 1'bz : sdi;
  assign sdo    = rd_active ? sdio : 1'b0;
  assign o_cs   = cs;
  assign o_sclk = sclk;

endmodule
